// File: rtl/wordle_pkg.sv
// Shared constants for the Wordle engine: letter codes, per-position feedback codes and FSM states.
package wordle_pkg;

  localparam int LETTER_BLANK = 0;
  localparam int LETTER_A     = 1;
  localparam int LETTER_Z     = 26;
  localparam int LETTER_BKSP  = 31;

  localparam logic [1:0] FB_NONE    = 2'b00;
  localparam logic [1:0] FB_ABSENT  = 2'b01;
  localparam logic [1:0] FB_PRESENT = 2'b10;
  localparam logic [1:0] FB_CORRECT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SCORE_EXACT,
    ST_SCORE_PRESENT,
    ST_SHOW,
    ST_WIN,
    ST_LOSE
  } state_t;

endpackage

// File: rtl/wordle_press_sync.sv
// Two-flop synchroniser on the active-low enter button plus a falling-edge detector.
// A 1->0 transition yields a one-cycle press pulse two edges later; no backpressure, presses are never queued.
module wordle_press_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic enter,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = enter;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Released button reads high, so resetting to 1 avoids a spurious press out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/wordle_engine.sv
// Wordle game engine: letter entry with backspace, duplicate-aware scoring, win/lose tracking.
// Scoring takes 1+WORD_LEN busy cycles; presses arriving while busy are dropped.
module wordle_engine
  import wordle_pkg::*;
#(
  parameter int WORD_LEN    = 4,
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enter,
  input  logic [LETTER_W-1:0]            letter_in,
  input  logic                           secret_load,
  input  logic [WORD_LEN*LETTER_W-1:0]   secret_in,
  output logic [WORD_LEN*LETTER_W-1:0]   guess,
  output logic [$clog2(WORD_LEN+1)-1:0]  entry_pos,
  output logic [2*WORD_LEN-1:0]          feedback,
  output logic [3:0]                     guess_count,
  output logic                           busy,
  output logic                           win,
  output logic                           lose
);

  localparam int GW    = WORD_LEN * LETTER_W;
  localparam int EP_W  = $clog2(WORD_LEN + 1);
  localparam int IDX_W = $clog2(WORD_LEN);

  logic press;

  wordle_press_sync u_press_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .enter (enter),
    .press (press)
  );

  state_t              state_q, state_d;
  logic [GW-1:0]       secret_q, secret_d;
  logic                secret_valid_q, secret_valid_d;
  logic [GW-1:0]       guess_q, guess_d;
  logic [EP_W-1:0]     entry_pos_q, entry_pos_d;
  logic [2*WORD_LEN-1:0] fb_q, fb_d;
  logic [3:0]          guess_count_q, guess_count_d;
  logic [WORD_LEN-1:0] used_q, used_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;

  logic [LETTER_W-1:0] g [WORD_LEN];
  logic [LETTER_W-1:0] s [WORD_LEN];
  logic [WORD_LEN-1:0] exact;

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      g[i]     = guess_q[i*LETTER_W +: LETTER_W];
      s[i]     = secret_q[i*LETTER_W +: LETTER_W];
      exact[i] = (g[i] == s[i]);
    end
  end

  // One guess position per cycle: find the lowest free, non-exact secret slot holding the same letter.
  logic [LETTER_W-1:0] cur_g;
  logic                cur_correct;
  logic                found;
  logic [WORD_LEN-1:0] hit;

  always_comb begin
    cur_g       = '0;
    cur_correct = 1'b0;
    found       = 1'b0;
    hit         = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_g       = g[i];
        cur_correct = (fb_q[2*i +: 2] == FB_CORRECT);
      end
    end
    for (int j = 0; j < WORD_LEN; j++) begin
      if (!found && !used_q[j] && !exact[j] && (s[j] == cur_g)) begin
        found  = 1'b1;
        hit[j] = 1'b1;
      end
    end
  end

  logic            is_letter;
  logic            is_bksp;
  logic [EP_W-1:0] ep_dec;
  logic [3:0]      gc_inc;

  always_comb begin
    is_letter = (letter_in >= LETTER_W'(LETTER_A)) && (letter_in <= LETTER_W'(LETTER_Z));
    is_bksp   = (letter_in == LETTER_W'(LETTER_BKSP));
    ep_dec    = entry_pos_q - EP_W'(1);
    gc_inc    = guess_count_q + 4'd1;
  end

  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    secret_valid_d = secret_valid_q;
    guess_d        = guess_q;
    entry_pos_d    = entry_pos_q;
    fb_d           = fb_q;
    guess_count_d  = guess_count_q;
    used_d         = used_q;
    idx_d          = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (secret_load) begin
          secret_d       = secret_in;
          secret_valid_d = 1'b1;
        end
        if (press && (secret_valid_q || secret_load)) begin
          guess_d       = '0;
          fb_d          = '0;
          entry_pos_d   = '0;
          guess_count_d = '0;
          used_d        = '0;
          state_d       = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (press) begin
          if (is_bksp) begin
            if (entry_pos_q != '0) begin
              entry_pos_d = ep_dec;
              for (int i = 0; i < WORD_LEN; i++) begin
                if (EP_W'(i) == ep_dec) guess_d[i*LETTER_W +: LETTER_W] = LETTER_W'(LETTER_BLANK);
              end
            end
          end else if (entry_pos_q == EP_W'(WORD_LEN)) begin
            state_d = ST_SCORE_EXACT;
          end else if (is_letter) begin
            entry_pos_d = entry_pos_q + EP_W'(1);
            for (int i = 0; i < WORD_LEN; i++) begin
              if (EP_W'(i) == entry_pos_q) guess_d[i*LETTER_W +: LETTER_W] = letter_in;
            end
          end
        end
      end

      ST_SCORE_EXACT: begin
        // Non-exact positions are cleared so feedback kept from the previous guess cannot leak in.
        for (int i = 0; i < WORD_LEN; i++) begin
          fb_d[2*i +: 2] = exact[i] ? FB_CORRECT : FB_NONE;
        end
        used_d  = exact;
        idx_d   = '0;
        state_d = ST_SCORE_PRESENT;
      end

      ST_SCORE_PRESENT: begin
        if (!cur_correct) begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (IDX_W'(i) == idx_q) fb_d[2*i +: 2] = found ? FB_PRESENT : FB_ABSENT;
          end
          used_d = used_q | hit;
        end
        if (idx_q == IDX_W'(WORD_LEN - 1)) begin
          idx_d = '0;
          if (&exact) begin
            state_d = ST_WIN;
          end else begin
            guess_count_d = gc_inc;
            state_d       = (gc_inc == 4'(MAX_GUESSES)) ? ST_LOSE : ST_SHOW;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_SHOW: begin
        if (press) begin
          guess_d     = '0;
          entry_pos_d = '0;
          state_d     = ST_ENTRY;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (press) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCORE_EXACT) || (state_d == ST_SCORE_PRESENT);
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      secret_q       <= '0;
      secret_valid_q <= 1'b0;
      guess_q        <= '0;
      entry_pos_q    <= '0;
      fb_q           <= '0;
      guess_count_q  <= '0;
      used_q         <= '0;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      secret_valid_q <= secret_valid_d;
      guess_q        <= guess_d;
      entry_pos_q    <= entry_pos_d;
      fb_q           <= fb_d;
      guess_count_q  <= guess_count_d;
      used_q         <= used_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
    end
  end

  assign guess       = guess_q;
  assign entry_pos   = entry_pos_q;
  assign feedback    = fb_q;
  assign guess_count = guess_count_q;
  assign busy        = busy_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
